// File: rtl/imem_boot_ctrl.sv
// UART boot loader for the instruction memory: receives a length-prefixed, checksummed
// image, writes it word by word, and gates CPU instruction fetch while loading or invalid.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned TIMEOUT    = 1_000_000,
    parameter bit          INIT_VALID = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       instr,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [15:0]       new_len;
    logic              unused_pc_lsb;

    assign new_len       = {len_q[15:8], rx_data};
    assign unused_pc_lsb = ^cpu_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
            valid_q <= INIT_VALID;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        idle_d  = idle_q;
        valid_d = valid_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (load_req) begin
                    state_d = LEN_HI;
                    len_d   = '0;
                end
            end
            LEN_HI, LEN_LO, DATA, CHECK: begin
                // A received byte takes priority over an expiring idle counter.
                if (rx_valid) begin
                    idle_d = '0;
                    case (state_q)
                        LEN_HI: begin
                            len_d[15:8] = rx_data;
                            state_d     = LEN_LO;
                        end
                        LEN_LO: begin
                            len_d[7:0] = rx_data;
                            widx_d     = '0;
                            csum_d     = '0;
                            bcnt_d     = '0;
                            if (new_len == 16'd0 || {1'b0, new_len} > MAX_WORDS) begin
                                state_d = ERR;
                            end else begin
                                state_d = DATA;
                            end
                        end
                        DATA: begin
                            csum_d = csum_q ^ rx_data;
                            bcnt_d = bcnt_q + 2'd1;
                            if (bcnt_q == 2'd3) begin
                                we_d    = 1'b1;
                                waddr_d = widx_q;
                                wdata_d = {word_q, rx_data};
                                widx_d  = widx_q + 1'b1;
                                if (16'(widx_q) == len_q - 16'd1) begin
                                    state_d = CHECK;
                                end
                            end else begin
                                word_d = {word_q[15:0], rx_data};
                            end
                        end
                        CHECK: begin
                            state_d = (rx_data == csum_q) ? DONE : ERR;
                        end
                        default: ;
                    endcase
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ERR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign load_done = (state_q == DONE);
    assign load_err  = (state_q == ERR);
    assign cpu_stall = busy | ~valid_q;
    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign mem_raddr = cpu_pc[ADDR_W+1:2];

    always_comb begin
        if (cpu_stall) begin
            instr = '0;
        end else if (|cpu_pc[31:ADDR_W+2]) begin
            instr = 32'h8000_0000;
        end else begin
            instr = mem_rdata;
        end
    end

endmodule
